// File: rtl/hart_state_unit_if.sv
// Signal bundle between the ID/IF/MEM stages and the hart state table.
// The master side raises start/kill/miss/fin events and the slave side reports per-hart state.
interface hart_state_unit_if;
    logic       id_hstart;
    logic       id_hkill;
    logic [1:0] id_set_hid;
    logic       hart_ic_flush;
    logic [1:0] ic_miss_hid;
    logic       i_cache_fin;
    logic       hart_dc_flush;
    logic [1:0] dc_miss_hid;
    logic       d_cache_fin;
    logic [3:0] run_hstate;
    logic [3:0] acti_hstate;
    logic [3:0] prim_hstate;
    logic [1:0] free_hid;
    logic       no_free_hart;

    modport master (
        output id_hstart, id_hkill, id_set_hid,
        output hart_ic_flush, ic_miss_hid, i_cache_fin,
        output hart_dc_flush, dc_miss_hid, d_cache_fin,
        input  run_hstate, acti_hstate, prim_hstate, free_hid, no_free_hart
    );

    modport slave (
        input  id_hstart, id_hkill, id_set_hid,
        input  hart_ic_flush, ic_miss_hid, i_cache_fin,
        input  hart_dc_flush, dc_miss_hid, d_cache_fin,
        output run_hstate, acti_hstate, prim_hstate, free_hid, no_free_hart
    );
endinterface

// File: rtl/hart_state_unit.sv
// Hart state table for the 4-hart barrel core: run/wait bits, one I- and one D-miss slot,
// and the primary hart. All outputs come from registers or from the registered run vector.
module hart_state_unit (
    input  logic              clk,
    input  logic              rst,
    hart_state_unit_if.slave  hs
);

    logic [3:0] run_q, run_d;
    logic [3:0] icWait_q, icWait_d;
    logic [3:0] dcWait_q, dcWait_d;
    logic [3:0] prim_q, prim_d;
    logic [3:0] acti_q, acti_d;
    logic       icValid_q, icValid_d;
    logic       dcValid_q, dcValid_d;
    logic [1:0] icHid_q, icHid_d;
    logic [1:0] dcHid_q, dcHid_d;
    logic       icAccept, dcAccept, startAccept;
    logic [1:0] freeHid;

    // Events are layered fin -> miss -> start -> kill so the later layer overrides
    // the earlier one, giving kill the final word on its hart.
    always_comb begin
        run_d     = run_q;
        icWait_d  = icWait_q;
        dcWait_d  = dcWait_q;
        prim_d    = prim_q;
        icValid_d = icValid_q;
        dcValid_d = dcValid_q;
        icHid_d   = icHid_q;
        dcHid_d   = dcHid_q;

        icAccept = hs.hart_ic_flush && run_q[hs.ic_miss_hid]
                   && (!icValid_q || hs.i_cache_fin)
                   && !(hs.id_hkill && hs.id_set_hid == hs.ic_miss_hid);
        dcAccept = hs.hart_dc_flush && run_q[hs.dc_miss_hid]
                   && (!dcValid_q || hs.d_cache_fin)
                   && !(hs.id_hkill && hs.id_set_hid == hs.dc_miss_hid);
        startAccept = hs.id_hstart && !run_q[hs.id_set_hid] && !hs.id_hkill;

        if (hs.i_cache_fin && icValid_q) begin
            icWait_d[icHid_q] = 1'b0;
            icValid_d         = 1'b0;
        end
        if (hs.d_cache_fin && dcValid_q) begin
            dcWait_d[dcHid_q] = 1'b0;
            dcValid_d         = 1'b0;
        end

        if (icAccept) begin
            icValid_d                 = 1'b1;
            icHid_d                   = hs.ic_miss_hid;
            icWait_d[hs.ic_miss_hid]  = 1'b1;
        end
        if (dcAccept) begin
            dcValid_d                 = 1'b1;
            dcHid_d                   = hs.dc_miss_hid;
            dcWait_d[hs.dc_miss_hid]  = 1'b1;
        end

        if (startAccept) begin
            run_d[hs.id_set_hid]    = 1'b1;
            icWait_d[hs.id_set_hid] = 1'b0;
            dcWait_d[hs.id_set_hid] = 1'b0;
            if (prim_q == 4'b0000) begin
                prim_d = 4'b0001 << hs.id_set_hid;
            end
        end

        // A slot reloaded for another hart this cycle must survive the kill,
        // so compare against the next-state slot rather than the current one.
        if (hs.id_hkill) begin
            run_d[hs.id_set_hid]    = 1'b0;
            icWait_d[hs.id_set_hid] = 1'b0;
            dcWait_d[hs.id_set_hid] = 1'b0;
            if (icValid_d && icHid_d == hs.id_set_hid) begin
                icValid_d = 1'b0;
            end
            if (dcValid_d && dcHid_d == hs.id_set_hid) begin
                dcValid_d = 1'b0;
            end
            if (prim_q[hs.id_set_hid]) begin
                prim_d = run_d & (~run_d + 4'd1);
            end
        end

        acti_d = run_d & ~icWait_d & ~dcWait_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= 4'b0001;
            icWait_q  <= 4'b0000;
            dcWait_q  <= 4'b0000;
            prim_q    <= 4'b0001;
            acti_q    <= 4'b0001;
            icValid_q <= 1'b0;
            dcValid_q <= 1'b0;
            icHid_q   <= 2'd0;
            dcHid_q   <= 2'd0;
        end else begin
            run_q     <= run_d;
            icWait_q  <= icWait_d;
            dcWait_q  <= dcWait_d;
            prim_q    <= prim_d;
            acti_q    <= acti_d;
            icValid_q <= icValid_d;
            dcValid_q <= dcValid_d;
            icHid_q   <= icHid_d;
            dcHid_q   <= dcHid_d;
        end
    end

    always_comb begin
        freeHid = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!run_q[i]) begin
                freeHid = 2'(i);
            end
        end
    end

    assign hs.run_hstate   = run_q;
    assign hs.acti_hstate  = acti_q;
    assign hs.prim_hstate  = prim_q;
    assign hs.free_hid     = freeHid;
    assign hs.no_free_hart = &run_q;

endmodule
